// File: rtl/exec_if.sv
// Decode-to-memory handshake bundle for the execute stage.
// The stage side takes the slave modport; decode/memory drivers take master.
interface exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic [4:0]       in_rd;
    logic             in_wr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cmp;
    logic [4:0]       out_rd;
    logic             out_wr;
    logic             busy;
    logic             illegal;

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_rd, in_wr, out_ready,
        output in_ready, out_valid, out_result, out_cmp, out_rd, out_wr, busy, illegal
    );

    modport master (
        output in_valid, in_op, in_x, in_y, in_rd, in_wr, out_ready,
        input  in_ready, out_valid, out_result, out_cmp, out_rd, out_wr, busy, illegal
    );
endinterface

// File: rtl/exec_stage.sv
// MIRI execute stage: single-cycle ALU ops into a one-entry output register,
// plus a fixed-latency multiply that stalls decode while it counts down.
module exec_stage #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 5
) (
    input logic   clk,
    input logic   reset,
    exec_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_SLL = 5'd6;
    localparam logic [4:0] OP_SRL = 5'd7;
    localparam logic [4:0] OP_MV  = 5'd8;
    localparam logic [4:0] OP_LT  = 5'd9;
    localparam logic [4:0] OP_GT  = 5'd10;
    localparam logic [4:0] OP_EQ  = 5'd11;
    localparam logic [4:0] OP_JMP = 5'd12;

    localparam int                 CNT_W    = 4;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [WIDTH-1:0]   SH_LIM   = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_MUL
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_cmp;
    logic [4:0]         r_rd;
    logic               r_wr;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_mx;
    logic [WIDTH-1:0]   r_my;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_result;
    logic               w_cmp;
    logic               w_legal;
    logic [WIDTH-1:0]   w_prod;

    assign w_in_ready = !reset && ((r_state == S_EMPTY) ||
                                   ((r_state == S_FULL) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mul   = (bus.in_op == OP_MUL);

    // Product is read only once the countdown expires, so the multiplier
    // has MUL_LATENCY cycles of settling time from the captured operands.
    assign w_prod = r_mx * r_my;

    always_comb begin
        w_result = '0;
        w_cmp    = 1'b0;
        w_legal  = 1'b1;
        case (bus.in_op)
            OP_ADD:  w_result = bus.in_x + bus.in_y;
            OP_SUB:  w_result = bus.in_x - bus.in_y;
            OP_MUL:  w_result = '0;
            OP_OR:   w_result = bus.in_x | bus.in_y;
            OP_AND:  w_result = bus.in_x & bus.in_y;
            OP_XOR:  w_result = bus.in_x ^ bus.in_y;
            OP_SLL:  w_result = (bus.in_y >= SH_LIM) ? '0 : (bus.in_x << bus.in_y);
            OP_SRL:  w_result = (bus.in_y >= SH_LIM) ? '0 : (bus.in_x >> bus.in_y);
            OP_MV:   w_result = bus.in_x;
            OP_LT:   w_cmp    = (bus.in_x <  bus.in_y);
            OP_GT:   w_cmp    = (bus.in_x >  bus.in_y);
            OP_EQ:   w_cmp    = (bus.in_x == bus.in_y);
            OP_JMP:  w_result = bus.in_x + bus.in_y;
            default: w_legal  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept && w_is_mul) begin
            r_mx <= bus.in_x;
            r_my <= bus.in_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_EMPTY;
            r_cnt     <= '0;
            r_result  <= '0;
            r_cmp     <= 1'b0;
            r_rd      <= '0;
            r_wr      <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            case (r_state)
                S_EMPTY, S_FULL: begin
                    if (w_accept) begin
                        // Tag and write enable are parked now so they stay
                        // paired with the product when it lands.
                        r_rd <= bus.in_rd;
                        if (w_is_mul) begin
                            r_state  <= S_MUL;
                            r_cnt    <= CNT_LOAD;
                            r_result <= '0;
                            r_cmp    <= 1'b0;
                            r_wr     <= bus.in_wr;
                        end else begin
                            r_state  <= S_FULL;
                            r_result <= w_result;
                            r_cmp    <= w_cmp;
                            r_wr     <= bus.in_wr && w_legal;
                        end
                    end else if ((r_state == S_FULL) && bus.out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_result <= w_prod;
                        r_state  <= S_FULL;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_FULL);
    assign bus.busy       = (r_state == S_MUL);
    assign bus.out_result = r_result;
    assign bus.out_cmp    = r_cmp;
    assign bus.out_rd     = r_rd;
    assign bus.out_wr     = r_wr;
    assign bus.illegal    = r_illegal;
endmodule

// File: tb/tb_exec_stage.sv
// Testbench for exec_stage: directed vector table, MUL/reset corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_exec_stage;
    localparam int W   = 32;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exec_if #(.WIDTH(W)) u_if();

    exec_stage #(.WIDTH(W), .MUL_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic [4:0]  rd;
        logic        wr;
    } res_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] e_res;
        logic        e_cmp;
        logic        e_wr;
        logic        e_ill;
    } vec_t;

    res_t q[$];
    int   mul_left;
    logic ill_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference semantics straight from the opcode table, in 64-bit arithmetic.
    function automatic res_t ref_op(input logic [4:0] op, input logic [31:0] x,
                                    input logic [31:0] y, input logic [4:0] rd, input logic wr);
        res_t r;
        longint unsigned a = 64'(x);
        longint unsigned b = 64'(y);
        r.res = 32'd0; r.cmp = 1'b0; r.rd = rd; r.wr = wr;
        case (op)
            5'd0:  r.res = 32'(a + b);
            5'd1:  r.res = 32'(a - b);
            5'd2:  r.res = 32'(a * b);
            5'd3:  r.res = x | y;
            5'd4:  r.res = x & y;
            5'd5:  r.res = x ^ y;
            5'd6:  r.res = (b >= 32) ? 32'd0 : 32'(a << b);
            5'd7:  r.res = (b >= 32) ? 32'd0 : 32'(a >> b);
            5'd8:  r.res = x;
            5'd9:  r.cmp = (a < b);
            5'd10: r.cmp = (a > b);
            5'd11: r.cmp = (a == b);
            5'd12: r.res = 32'(a + b);
            default: r.wr = 1'b0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        mul_left = 0;
        ill_exp  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        u_if.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock of model-checked traffic: drive at negedge, check, advance model.
    task automatic step(input logic iv, input logic [4:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] rd, input logic wr,
                        input logic ordy, output logic acc, output logic cons);
        logic e_valid, e_ready;
        res_t f;
        @(negedge clk);
        u_if.in_valid  = iv;
        u_if.in_op     = op;
        u_if.in_x      = x;
        u_if.in_y      = y;
        u_if.in_rd     = rd;
        u_if.in_wr     = wr;
        u_if.out_ready = ordy;
        #1;
        e_valid = (q.size() > 0) && (mul_left == 0);
        e_ready = (mul_left == 0) && (!e_valid || ordy);
        chk("out_valid", 32'(u_if.out_valid), 32'(e_valid));
        chk("in_ready",  32'(u_if.in_ready),  32'(e_ready));
        chk("busy",      32'(u_if.busy),      32'(mul_left > 0));
        chk("illegal",   32'(u_if.illegal),   32'(ill_exp));
        if (e_valid) begin
            f = q[0];
            chk("out_result", u_if.out_result, f.res);
            chk("out_cmp", 32'(u_if.out_cmp), 32'(f.cmp));
            chk("out_rd",  32'(u_if.out_rd),  32'(f.rd));
            chk("out_wr",  32'(u_if.out_wr),  32'(f.wr));
        end
        acc  = iv && e_ready;
        cons = e_valid && ordy;
        if (cons) void'(q.pop_front());
        if (mul_left > 0) mul_left--;
        if (acc) begin
            q.push_back(ref_op(op, x, y, rd, wr));
            if (op == 5'd2) mul_left = LAT;
        end
        ill_exp = acc && (op > 5'd12);
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] rd, input logic wr);
        int n = 0;
        @(negedge clk);
        while (!u_if.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(u_if.in_ready), 32'd1);
        u_if.in_op    = op;
        u_if.in_x     = x;
        u_if.in_y     = y;
        u_if.in_rd    = rd;
        u_if.in_wr    = wr;
        u_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    vec_t tbl[17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc, cons;
        int   sent, got, n;

        tbl[0]  = '{5'd0,  32'd5,          32'd7,          5'd3,  1'b1, 32'd12,         1'b0, 1'b1, 1'b0};
        tbl[1]  = '{5'd1,  32'd0,          32'd1,          5'd4,  1'b1, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
        tbl[2]  = '{5'd2,  32'd3,          32'd4,          5'd5,  1'b1, 32'd12,         1'b0, 1'b1, 1'b0};
        tbl[3]  = '{5'd2,  32'h0001_0000,  32'h0001_0000,  5'd6,  1'b0, 32'd0,          1'b0, 1'b0, 1'b0};
        tbl[4]  = '{5'd9,  32'd3,          32'd5,          5'd7,  1'b1, 32'd0,          1'b1, 1'b1, 1'b0};
        tbl[5]  = '{5'd11, 32'd9,          32'd9,          5'd8,  1'b1, 32'd0,          1'b1, 1'b1, 1'b0};
        tbl[6]  = '{5'd10, 32'd2,          32'd8,          5'd9,  1'b1, 32'd0,          1'b0, 1'b1, 1'b0};
        tbl[7]  = '{5'd6,  32'd1,          32'd31,         5'd10, 1'b1, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
        tbl[8]  = '{5'd7,  32'hFFFF_FFFF,  32'd40,         5'd11, 1'b1, 32'd0,          1'b0, 1'b1, 1'b0};
        tbl[9]  = '{5'd20, 32'd7,          32'd9,          5'd12, 1'b1, 32'd0,          1'b0, 1'b0, 1'b1};
        tbl[10] = '{5'd8,  32'hDEAD_BEEF,  32'd5,          5'd13, 1'b1, 32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0};
        tbl[11] = '{5'd12, 32'h0000_0100,  32'h0000_0024,  5'd14, 1'b0, 32'h0000_0124,  1'b0, 1'b0, 1'b0};
        tbl[12] = '{5'd3,  32'h0000_F0F0,  32'h0000_0F0F,  5'd15, 1'b1, 32'h0000_FFFF,  1'b0, 1'b1, 1'b0};
        tbl[13] = '{5'd4,  32'hFF00_FF00,  32'h0FF0_0FF0,  5'd16, 1'b1, 32'h0F00_0F00,  1'b0, 1'b1, 1'b0};
        tbl[14] = '{5'd5,  32'hAAAA_5555,  32'hFFFF_0000,  5'd17, 1'b1, 32'h5555_5555,  1'b0, 1'b1, 1'b0};
        tbl[15] = '{5'd7,  32'h8000_0000,  32'd31,         5'd18, 1'b1, 32'd1,          1'b0, 1'b1, 1'b0};
        tbl[16] = '{5'd6,  32'd1,          32'd32,         5'd31, 1'b1, 32'd0,          1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        u_if.in_valid = 1'b0; u_if.in_op = '0; u_if.in_x = '0; u_if.in_y = '0;
        u_if.in_rd = '0; u_if.in_wr = 1'b0; u_if.out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(u_if.in_ready),  32'd0);
        chk("rst_busy",      32'(u_if.busy),      32'd0);
        chk("rst_result",    u_if.out_result,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(u_if.in_ready), 32'd1);

        // Directed vector table, memory stage always ready.
        foreach (tbl[i]) begin
            send(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].rd, tbl[i].wr);
            @(negedge clk);
            chk($sformatf("v%0d_illegal", i), 32'(u_if.illegal), 32'(tbl[i].e_ill));
            n = 0;
            while (!u_if.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("v%0d_valid", i),  32'(u_if.out_valid), 32'd1);
            chk($sformatf("v%0d_result", i), u_if.out_result,     tbl[i].e_res);
            chk($sformatf("v%0d_cmp", i),    32'(u_if.out_cmp),   32'(tbl[i].e_cmp));
            chk($sformatf("v%0d_rd", i),     32'(u_if.out_rd),    32'(tbl[i].rd));
            chk($sformatf("v%0d_wr", i),     32'(u_if.out_wr),    32'(tbl[i].e_wr));
        end

        // MUL latency: busy/in_ready low for LAT cycles, then the product.
        repeat (2) @(negedge clk);
        send(5'd2, 32'd3, 32'd4, 5'd21, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk($sformatf("mul_busy_c%0d", k),     32'(u_if.busy),      32'd1);
            chk($sformatf("mul_in_ready_c%0d", k), 32'(u_if.in_ready),  32'd0);
            chk($sformatf("mul_valid_c%0d", k),    32'(u_if.out_valid), 32'd0);
        end
        @(negedge clk);
        chk("mul_done_valid",  32'(u_if.out_valid), 32'd1);
        chk("mul_done_result", u_if.out_result,     32'd12);
        chk("mul_done_busy",   32'(u_if.busy),      32'd0);
        chk("mul_done_rd",     32'(u_if.out_rd),    32'd21);

        // XOR stream with out_ready pattern 1,0,0,1.
        do_reset();
        sent = 0; got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            step(sent < 8, 5'd5, 32'h1111_0000 + 32'(sent), 32'h0000_00FF ^ 32'(sent),
                 5'(sent), 1'b1, (c % 4 == 0) || (c % 4 == 3), acc, cons);
            if (acc) sent++;
            if (cons) got++;
        end
        chk("xor_delivered", 32'(got), 32'd8);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [4:0]  op;
            logic [31:0] x, y;
            int          r;
            r = int'($urandom_range(0, 99));
            if (r < 10)      op = 5'd2;
            else if (r < 15) op = 5'($urandom_range(13, 31));
            else             op = 5'($urandom_range(0, 12));
            x = $urandom;
            case ($urandom_range(0, 2))
                0:       y = $urandom;
                1:       y = $urandom_range(0, 40);
                default: y = x;
            endcase
            step($urandom_range(0, 3) != 0, op, x, y, 5'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, acc, cons);
        end

        // Reset in the middle of a MUL (counter at 2) discards it.
        do_reset();
        u_if.out_ready = 1'b1;
        send(5'd2, 32'd6, 32'd7, 5'd9, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mulrst_valid",    32'(u_if.out_valid), 32'd0);
        chk("mulrst_busy",     32'(u_if.busy),      32'd0);
        chk("mulrst_in_ready", 32'(u_if.in_ready),  32'd0);
        chk("mulrst_result",   u_if.out_result,     32'd0);
        chk("mulrst_rd",       32'(u_if.out_rd),    32'd0);
        chk("mulrst_wr",       32'(u_if.out_wr),    32'd0);
        chk("mulrst_cmp",      32'(u_if.out_cmp),   32'd0);
        chk("mulrst_illegal",  32'(u_if.illegal),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mulrst_rel_in_ready", 32'(u_if.in_ready), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("mulrst_stale_c%0d", k), 32'(u_if.out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the MIRI pipeline. It accepts one decoded instruction per cycle from decode (opcode, two operands, destination tag), evaluates it with the ALU operation set, and presents a registered result to the memory stage over a valid/ready handshake. MUL runs as a fixed multi-cycle operation and stalls decode for its duration. Every other opcode completes in one cycle at full throughput.

## Interface
- WIDTH, `REG_FILE_WIDTH (32): datapath width.
- MUL_LATENCY, 5: cycles from MUL acceptance to result valid; legal range 2..16.
- clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle; transfer occurs when in_valid && in_ready at a rising edge.
- in_op  in  5  opcode: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 SLL, 7 SRL, 8 MV, 9 LT, 10 GT, 11 EQ, 12 JMP.
- in_x, in_y  in  WIDTH  operands.
- in_rd  in  5  destination register tag.
- in_wr  in  1  write-back requested.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  memory stage consumes the result this cycle.
- out_result  out  WIDTH  result value.
- out_cmp  out  1  comparison flag.
- out_rd  out  5  tag carried from the input.
- out_wr  out  1  write-back enable carried from the input.
- busy  out  1  MUL in flight.
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted.

## Operation
- State machine states: EMPTY, FULL and MUL.
  - EMPTY: the output register is empty.
  - FULL: out_valid=1.
  - MUL: the countdown counter is active.
- in_ready = !reset && (EMPTY || (FULL && out_ready)). in_ready is combinational and is 0 throughout MUL.
- Single-cycle accept: from EMPTY or FULL, the result is loaded into the output register and the state becomes FULL.
- Drain: in FULL, out_ready with no new accept moves the state to EMPTY.
- MUL accept: the state becomes MUL and the counter is loaded with MUL_LATENCY-1. If the stage was in FULL, the old result is consumed at the same edge.
- MUL countdown: the counter decrements each cycle. At counter 0 the product is written and the state becomes FULL.
- Arithmetic: all operations are unsigned and wrap modulo 2^WIDTH.
  - MUL: low WIDTH bits of x*y. The implementation may compute it iteratively or pipelined, but only the final value is visible.
  - SLL/SRL: the shift amount is the full y; y >= WIDTH yields 0.
  - MV: result is x.
  - JMP: result is x+y.
  - Logical ops: OR, AND, XOR.
- Compares (LT, GT, EQ): out_cmp = relation, out_result = 0. For every other opcode out_cmp = 0.
- Opcodes 13..31:
  - Accepted as single-cycle.
  - out_result=0, out_cmp=0, out_wr forced to 0.
  - illegal pulses high for the cycle following acceptance.
- out_rd and out_wr are captured at acceptance and stay aligned with their result, including across MUL.
- busy = (state == MUL).

## Timing
- Reset, asynchronous: the state goes to EMPTY and the counter clears. All outputs go to 0: out_valid, out_result, out_cmp, out_rd, out_wr, busy, illegal, and in_ready.
- Reset during MUL aborts the operation; no result is ever produced for it.
- Single-cycle latency: accept at edge N gives out_valid=1 in the cycle after edge N.
- Throughput: with out_ready held at 1, one single-cycle result per cycle.
- MUL latency: accept at edge N gives out_valid=1 after edge N+MUL_LATENCY. in_ready=0 from N+1 until that result is present.
- Stability: while out_valid && !out_ready, out_result, out_cmp, out_rd and out_wr are held constant and in_ready=0.
- Simultaneous drain and accept in FULL: the new result replaces the old one at the same edge with no bubble, and out_valid stays 1.
- No input fields are sampled when in_valid=0; the output register is unchanged.

## Test plan
- ADD: x=5, y=7, rd=3, wr=1 accepted at edge N -> cycle N+1 shows out_valid=1, result=12, rd=3, wr=1, cmp=0. SUB 0-1 -> 0xFFFFFFFF.
- Stream of 8 XORs with out_ready toggled 1,0,0,1,...:
  - every result is delivered exactly once, in order;
  - outputs are frozen while stalled;
  - in_ready mirrors out_ready while FULL.
- MUL: x=3, y=4 with MUL_LATENCY=5 -> busy=1 and in_ready=0 for cycles N+1..N+5, result 12 after edge N+5. A second MUL, 0x00010000*0x00010000, gives 0.
- Compares and shifts:
  - LT 3,5 -> cmp=1, result=0;
  - EQ 9,9 -> cmp=1;
  - GT 2,8 -> cmp=0;
  - SLL 1 by 31 -> 0x80000000;
  - SRL by 40 -> 0.
- Illegal opcode 20 with wr=1 -> illegal=1 for one cycle, out_valid=1, result=0, wr=0.
- Reset asserted at counter=2 of a MUL -> all outputs 0 immediately. After release: EMPTY, in_ready=1, no stale product appears.
